// File: rtl/cnt60_pkg.sv
// Shared state encoding and terminal-count constants for the 0-59 counter controller.
package cnt60_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] CNT_MAX_U = 4'h9;
    localparam logic [2:0] CNT_MAX_T = 3'd5;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability filter and accepted-rise pulse for one raw board input.
module btn_debounce #(
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          settle;

    // settle is high in the last cycle of a stable new level, so the rise pulse
    // is presented combinationally alongside the level update.
    assign settle = (s2 != level) && (cnt == CW'(DEBOUNCE - 1));
    assign rise   = settle && s2;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                cnt   <= '0;
                level <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt60_ctrl.sv
// Run/pause/clear controller for a 0-59 counter slice: prescaled count enable,
// direction latch, wrap detection and a timed down-count alarm.
module cnt60_ctrl
    import cnt60_pkg::*;
#(
    parameter int PRESCALE     = 50_000_000,
    parameter int DEBOUNCE     = 1_000_000,
    parameter int ALARM_CYCLES = 150_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_SS,
    input  logic       BTN_CLR,
    input  logic       SW_DEC,
    input  logic [3:0] CNT10,
    input  logic [2:0] CNT6,
    output logic       CNT_ENABLE,
    output logic       CNT_DEC,
    output logic       CNT_CLR,
    output logic       ALARM,
    output logic       WRAP,
    output logic [1:0] STATE
);
    localparam int PW = $clog2(PRESCALE);
    localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

    state_t        state, state_nx;
    logic          ss_p, clr_p, dec_lvl;
    logic          ss_lvl_unused, clr_lvl_unused, dec_rise_unused;
    logic [PW-1:0] psc;
    logic [AW-1:0] atm;
    logic          tick, at_59, at_01, alarm_done, en_nx, wrap_nx;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_ss  (.CLK(CLK), .RESET(RESET), .btn(BTN_SS),
                                               .level(ss_lvl_unused), .rise(ss_p));
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_clr (.CLK(CLK), .RESET(RESET), .btn(BTN_CLR),
                                               .level(clr_lvl_unused), .rise(clr_p));
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_dec (.CLK(CLK), .RESET(RESET), .btn(SW_DEC),
                                               .level(dec_lvl), .rise(dec_rise_unused));

    // Out-of-range digits simply never match a terminal value.
    assign tick       = (state == ST_RUN) && (psc == PW'(PRESCALE - 1));
    assign at_59      = (CNT10 == CNT_MAX_U) && (CNT6 == CNT_MAX_T);
    assign at_01      = (CNT10 == 4'd1) && (CNT6 == 3'd0);
    assign alarm_done = (atm == AW'(ALARM_CYCLES - 1));
    assign ALARM      = (state == ST_ALARM);
    assign STATE      = state;

    always_comb begin
        state_nx = state;
        en_nx    = 1'b0;
        wrap_nx  = 1'b0;
        case (state)
            ST_IDLE:  if (!clr_p && ss_p) state_nx = ST_RUN;
            ST_RUN: begin
                if (clr_p)     state_nx = ST_IDLE;
                else if (ss_p) state_nx = ST_PAUSE;
                else if (tick) begin
                    en_nx   = 1'b1;
                    wrap_nx = !CNT_DEC && at_59;
                    // Counter lands on 00 one cycle later, as ALARM goes up.
                    if (CNT_DEC && at_01) state_nx = ST_ALARM;
                end
            end
            ST_PAUSE: begin
                if (clr_p)     state_nx = ST_IDLE;
                else if (ss_p) state_nx = ST_RUN;
            end
            ST_ALARM: if (clr_p || ss_p || alarm_done) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            psc        <= '0;
            atm        <= '0;
            CNT_ENABLE <= 1'b0;
            CNT_CLR    <= 1'b0;
            WRAP       <= 1'b0;
            CNT_DEC    <= 1'b0;
        end else begin
            state      <= state_nx;
            CNT_ENABLE <= en_nx;
            WRAP       <= wrap_nx;
            CNT_CLR    <= clr_p;
            if (state == ST_IDLE) CNT_DEC <= dec_lvl;
            // Leaving RUN freezes the prescaler so a resume picks up where it stopped.
            if (state == ST_RUN) begin
                if (!(ss_p || clr_p)) psc <= tick ? '0 : psc + 1'b1;
            end else if (state != ST_PAUSE) begin
                psc <= '0;
            end
            atm <= (state == ST_ALARM && state_nx == ST_ALARM) ? atm + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_cnt60_ctrl.sv
// Directed scenario bench for cnt60_ctrl with a behavioural 0-59 counter attached.
module tb_cnt60_ctrl;
    localparam int PRESCALE = 4, DEBOUNCE = 2, ALARM_CYCLES = 8;

    logic       CLK = 1'b0, RESET = 1'b0, BTN_SS = 1'b0, BTN_CLR = 1'b0, SW_DEC = 1'b0;
    logic [3:0] CNT10;
    logic [2:0] CNT6;
    logic       CNT_ENABLE, CNT_DEC, CNT_CLR, ALARM, WRAP;
    logic [1:0] STATE;

    int   nvec = 0, nfail = 0;
    int   mcnt = 0, ld_val = 0, base = 0, nen = 0;
    logic ld_req = 1'b0, ovr = 1'b0;

    cnt60_ctrl #(.PRESCALE(PRESCALE), .DEBOUNCE(DEBOUNCE), .ALARM_CYCLES(ALARM_CYCLES)) dut (
        .CLK(CLK), .RESET(RESET), .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR), .SW_DEC(SW_DEC),
        .CNT10(CNT10), .CNT6(CNT6), .CNT_ENABLE(CNT_ENABLE), .CNT_DEC(CNT_DEC),
        .CNT_CLR(CNT_CLR), .ALARM(ALARM), .WRAP(WRAP), .STATE(STATE));

    always #5 CLK = ~CLK;

    // Counter slice shares the reset net; ovr forces an illegal digit pair onto the bus.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET)          mcnt <= 0;
        else if (ld_req)     mcnt <= ld_val;
        else if (CNT_CLR)    mcnt <= 0;
        else if (CNT_ENABLE) mcnt <= CNT_DEC ? (mcnt == 0 ? 59 : mcnt - 1)
                                             : (mcnt == 59 ? 0 : mcnt + 1);
    end
    assign CNT10 = ovr ? 4'd9 : 4'(mcnt % 10);
    assign CNT6  = ovr ? 3'd7 : 3'(mcnt / 10);

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Up-mode count equals preload plus enables already issued.
    task automatic trk(input string tag);
        chk(tag, mcnt, (base + nen) % 60);
        if (CNT_ENABLE) nen++;
    endtask

    initial begin
        int  plen, k, first;
        bit  done;

        repeat (3) step();
        chk("rst_state", STATE, 0);      chk("rst_en", CNT_ENABLE, 0);
        chk("rst_clr", CNT_CLR, 0);      chk("rst_alarm", ALARM, 0);
        chk("rst_wrap", WRAP, 0);        chk("rst_dec", CNT_DEC, 0);
        RESET = 1'b1;
        repeat (6) step();
        chk("idle_state", STATE, 0);

        // start, then enable every PRESCALE cycles
        base = 0; nen = 0;
        BTN_SS = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            step();
            if (i == 6) BTN_SS = 1'b0;
            if (i == 3) chk("t1_idle", STATE, 0);
            if (i >= 4) begin
                chk("t1_run", STATE, 1);
                chk("t1_en", CNT_ENABLE, (i > 4) && ((i - 4) % PRESCALE == 0));
                trk("t1_cnt");
            end
        end

        // press lands with prescaler at 2 -> pause, then resume from 2
        BTN_SS = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 5) BTN_SS = 1'b0;
            chk("t4_state", STATE, (i >= 4) ? 2 : 1);
            chk("t4_en", CNT_ENABLE, i == 1);
            trk("t4_cnt");
        end
        plen = 40 + int'($urandom_range(0, 20));
        for (int i = 0; i < plen; i++) begin
            step();
            chk("t4_pause_st", STATE, 2);
            chk("t4_pause_en", CNT_ENABLE, 0);
            trk("t4_pause_cnt");
        end
        first = 4 + (PRESCALE - 1 - 2) + 1;
        BTN_SS = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 5) BTN_SS = 1'b0;
            chk("t4_resume_st", STATE, (i >= 4) ? 1 : 2);
            chk("t4_resume_en", CNT_ENABLE, (i == first) || (i == first + PRESCALE));
            trk("t4_resume_cnt");
        end

        // direction frozen in RUN; simultaneous SS+CLR clears to IDLE
        SW_DEC = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t5_dec_frozen", CNT_DEC, 0);
            trk("t5_cnt");
        end
        SW_DEC = 1'b0;
        repeat (6) begin step(); trk("t5_cnt2"); end
        BTN_SS = 1'b1; BTN_CLR = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) begin BTN_SS = 1'b0; BTN_CLR = 1'b0; end
            chk("t5_no_pause", STATE != 2'd2, 1);
            if (i == 4) begin
                chk("t5_state", STATE, 0); chk("t5_clr", CNT_CLR, 1); chk("t5_en", CNT_ENABLE, 0);
            end
            if (i == 5) begin
                chk("t5_clr_width", CNT_CLR, 0); chk("t5_cnt0", mcnt, 0); chk("t5_en2", CNT_ENABLE, 0);
            end
        end

        // up-mode wrap 59 -> 00, then illegal digits never match
        ld_val = 58; ld_req = 1'b1; step(); ld_req = 1'b0;
        base = 58; nen = 0;
        BTN_SS = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 6) BTN_SS = 1'b0;
            if (i == 8)  begin chk("t2_en58", CNT_ENABLE, 1); chk("t2_wrap58", WRAP, 0); end
            if (i == 12) begin chk("t2_en59", CNT_ENABLE, 1); chk("t2_wrap", WRAP, 1); chk("t2_state", STATE, 1); end
            if (i == 13) begin chk("t2_wrap_width", WRAP, 0); chk("t2_cnt00", mcnt, 0); end
            if (i >= 4) trk("t2_cnt");
        end
        ovr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t2_ill_wrap", WRAP, 0);
            chk("t2_ill_en", CNT_ENABLE, i % PRESCALE == 0);
        end
        ovr = 1'b0;
        BTN_CLR = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) BTN_CLR = 1'b0;
            if (i == 4) begin chk("t2_clr", CNT_CLR, 1); chk("t2_clr_st", STATE, 0); chk("t2_clr_en", CNT_ENABLE, 0); end
            if (i == 5) chk("t2_clr_cnt", mcnt, 0);
        end

        // down mode from 00: 59 .. 01, alarm on reaching 00, timed return
        SW_DEC = 1'b1;
        repeat (6) step();
        chk("t3_dec", CNT_DEC, 1);
        BTN_SS = 1'b1; k = 0; done = 1'b0;
        for (int i = 1; i <= 400 && !done; i++) begin
            step();
            if (i == 5) BTN_SS = 1'b0;
            if (CNT_ENABLE) begin
                k++;
                chk("t3_cnt", mcnt, (60 - (k - 1)) % 60);
                chk("t3_state", STATE, (k == 60) ? 3 : 1);
                chk("t3_alarm_at", ALARM, k == 60);
                if (k == 60) done = 1'b1;
            end
        end
        chk("t3_alarm_reached", done, 1);
        for (int i = 1; i <= ALARM_CYCLES; i++) begin
            step();
            chk("t3_alarm", ALARM, i < ALARM_CYCLES);
            chk("t3_cnt00", mcnt, 0);
            chk("t3_dec_frozen", CNT_DEC, 1);
        end
        chk("t3_idle", STATE, 0);

        // asynchronous reset mid-run, then a too-short glitch
        BTN_SS = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 5) BTN_SS = 1'b0;
        end
        chk("t6_pre_en", CNT_ENABLE, 1);
        chk("t6_pre_dec", CNT_DEC, 1);
        #2 RESET = 1'b0;
        #1;
        chk("t6_async_st", STATE, 0);     chk("t6_async_en", CNT_ENABLE, 0);
        chk("t6_async_dec", CNT_DEC, 0);  chk("t6_async_alarm", ALARM, 0);
        chk("t6_async_wrap", WRAP, 0);    chk("t6_async_clr", CNT_CLR, 0);
        chk("t6_async_cnt", mcnt, 0);
        RESET = 1'b1;
        step();
        chk("t6_rel_st", STATE, 0);
        chk("t6_rel_dec", CNT_DEC, 0);
        BTN_SS = 1'b1; BTN_CLR = 1'b1;
        step();
        BTN_SS = 1'b0; BTN_CLR = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t6_glitch_st", STATE, 0);
            chk("t6_glitch_clr", CNT_CLR, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/cnt60_ctrl.md
Name: cnt60_ctrl

Overview:
Run/pause/clear controller that sequences one 0–59 counter slice (count enable, direction, clear) from two push-buttons and a direction switch.
Contains a prescaler that produces the count tick, button synchronisers/debouncers, and a 4-state FSM.
In down mode it raises an alarm when the count reaches 00.
It sits between the board I/O and the counter, and reads the counter's CNT10/CNT6 back for terminal detection.

Parameters:
PRESCALE, 50_000_000, CLK cycles per count tick (>=2); prescaler width = clog2(PRESCALE)
DEBOUNCE, 1_000_000, cycles a synchronised button level must be stable before it is accepted (>=1)
ALARM_CYCLES, 150_000_000, cycles ALARM stays high before auto-return to IDLE (>=1)

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  asynchronous, active-low reset
BTN_SS  in  1  start/stop button, raw, asynchronous, active-high
BTN_CLR  in  1  clear button, raw, asynchronous, active-high
SW_DEC  in  1  direction switch: 0 = up, 1 = down; raw level
CNT10  in  4  counter units digit (0–9)
CNT6  in  3  counter tens digit (0–5)
CNT_ENABLE  out  1  one-cycle count-enable pulse to the counter
CNT_DEC  out  1  direction to the counter (latched copy of SW_DEC)
CNT_CLR  out  1  one-cycle active-high clear pulse to the counter's reset
ALARM  out  1  high while in ALARM state
WRAP  out  1  one-cycle pulse when an up-count wraps 59 -> 00
STATE  out  2  FSM state for display/debug: 0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM

Behaviour:
- Reset (RESET=0, asynchronous):
  - STATE=IDLE; all outputs 0; CNT_DEC=0.
  - Prescaler, debounce counters, alarm timer and synchronisers cleared.
  - Reset mid-run discards all progress; no CNT_CLR pulse is issued, because the counter shares the same reset net.
- Input conditioning (each of BTN_SS, BTN_CLR, SW_DEC):
  - 2-FF synchroniser, then debounce counter. The accepted level changes only after DEBOUNCE consecutive cycles of a new level.
  - SS_P / CLR_P are one-cycle pulses on the accepted 0->1 edge.
  - Press-to-pulse latency = 2 + DEBOUNCE cycles.
- CNT_DEC: loads the debounced SW_DEC every cycle in IDLE; frozen in RUN, PAUSE and ALARM.
- Prescaler:
  - Counts only in RUN; TICK when count == PRESCALE-1, then wraps to 0.
  - Holds its value in PAUSE.
  - Cleared to 0 on entry to RUN from IDLE and in IDLE/ALARM.
- CNT_ENABLE = TICK while in RUN; never asserted in any other state.
- FSM (evaluated each cycle; CLR_P has priority over SS_P when both occur in the same cycle):
  - IDLE: CLR_P -> IDLE + CNT_CLR pulse. SS_P -> RUN.
  - RUN, CLR_P -> IDLE + CNT_CLR.
  - RUN, SS_P -> PAUSE; a TICK in the same cycle is suppressed.
  - RUN, TICK, CNT_DEC=0, count == 59 -> CNT_ENABLE and WRAP in the same cycle; stay in RUN.
  - RUN, TICK, CNT_DEC=1, count == 01 -> CNT_ENABLE, then ALARM (the counter reaches 00).
  - RUN, down mode starting from 00: wraps to 59 normally (no alarm on start).
  - PAUSE: CLR_P -> IDLE + CNT_CLR. SS_P -> RUN, prescaler resumes from its held value.
  - ALARM: ALARM=1; alarm timer counts. CLR_P -> IDLE + CNT_CLR. SS_P, or timer == ALARM_CYCLES-1 -> IDLE, with no clear (display keeps 00).
- Output timing:
  - CNT_ENABLE, CNT_CLR and WRAP are registered outputs.
  - "Count" means {CNT6, CNT10} as sampled on the same edge as TICK.
- CNT_CLR is exactly 1 cycle wide; the controller never asserts CNT_ENABLE in the cycle after CNT_CLR.
- Illegal CNT10 > 9 or CNT6 > 5: no terminal match; the controller keeps ticking.

Decomposition:
- Shared package cnt60_pkg:
  - state typedef/constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_ALARM=2'd3
  - terminal constants CNT_MAX_U=4'h9, CNT_MAX_T=3'd5
- Sub-module btn_debounce: synchroniser + debounce + rising-edge pulse, parameter DEBOUNCE; instantiated 3 times (the SW_DEC instance uses the level output only).
- Prescaler, FSM and alarm timer stay in the top module.

Test Plan:
Use PRESCALE=4, DEBOUNCE=2, ALARM_CYCLES=8, with a behavioural counter model attached.
1. Reset then SS press (held 6 cycles) -> STATE=RUN 4 cycles after the press; CNT_ENABLE pulses every 4th cycle; counter goes 00, 01, 02.
2. Up mode, run to 59 -> on the next TICK, CNT_ENABLE=1 and WRAP=1 in the same cycle; counter = 00; STATE stays RUN.
3. Down mode (SW_DEC=1 in IDLE), start from 00 -> 59, 58 ... 01; on the tick 01->00, ALARM=1 and STATE=3. ALARM drops after 8 cycles; STATE=IDLE; count stays 00.
4. RUN, SS press at prescaler=2 -> PAUSE with no CNT_ENABLE for 50 cycles. SS again -> first CNT_ENABLE exactly 1 prescaler step after RUN re-entry.
5. BTN_SS and BTN_CLR pressed simultaneously in RUN -> CNT_CLR 1-cycle pulse, STATE=IDLE, counter = 00; no PAUSE seen. Toggling SW_DEC during RUN leaves CNT_DEC unchanged.
6. RESET asserted asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately; STATE=IDLE after release. A 1-cycle button glitch (< DEBOUNCE) produces no transition.
